// File: rtl/dct_pkg.sv
// Shared constants for the IDCT product generator: default widths, the
// shift applied to raw products, the output FSM state type and the 8x8
// cosine table T[i][k] = round(128 * c_k * cos((2i+1) * k * pi / 16)).
package dct_pkg;

  localparam int COEF_W_DEF = 12;
  localparam int PROD_W_DEF = 14;
  localparam int SHIFT_DEF  = 5;
  localparam int T_W        = 9;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } emit_state_t;

  typedef logic signed [T_W-1:0] tcoef_t;

  // Row index i (output sample), column index k (coefficient term).
  localparam tcoef_t T_TABLE [8][8] = '{
    '{9'sd91,  9'sd126,  9'sd118,  9'sd106,  9'sd91,  9'sd71,   9'sd49,   9'sd25},
    '{9'sd91,  9'sd106,  9'sd49,  -9'sd25,  -9'sd91, -9'sd126, -9'sd118, -9'sd71},
    '{9'sd91,  9'sd71,  -9'sd49,  -9'sd126, -9'sd91,  9'sd25,   9'sd118,  9'sd106},
    '{9'sd91,  9'sd25,  -9'sd118, -9'sd71,   9'sd91,  9'sd106, -9'sd49,  -9'sd126},
    '{9'sd91, -9'sd25,  -9'sd118,  9'sd71,   9'sd91, -9'sd106, -9'sd49,   9'sd126},
    '{9'sd91, -9'sd71,  -9'sd49,   9'sd126, -9'sd91, -9'sd25,   9'sd118, -9'sd106},
    '{9'sd91, -9'sd106,  9'sd49,   9'sd25,  -9'sd91,  9'sd126, -9'sd118,  9'sd71},
    '{9'sd91, -9'sd126,  9'sd118, -9'sd106,  9'sd91, -9'sd71,   9'sd49,  -9'sd25}
  };

endpackage

// File: rtl/idct_cos_rom.sv
// Combinational cosine lookup: (row i, term k) -> T[i][k].
// One instance sits in front of each product lane.
module idct_cos_rom
  import dct_pkg::*;
(
  input  logic [2:0]           row,
  input  logic [2:0]           term,
  output logic signed [T_W-1:0] t
);

  // Pure table read; no state.
  always_comb begin
    t = T_TABLE[row][term];
  end

endmodule

// File: rtl/idct_prod_gen.sv
// IDCT product generator. Coefficients X_0..X_7 are written into one of two
// ping-pong banks; once a bank holds a full frame, the output FSM walks rows
// i = 0..7, one per cycle, and each of the 8 lanes forms X_k * T[i][k] >>> SHIFT.
// Products are registered once, so row 0 appears two edges after the frame
// completes. A bank is released when its row 7 is emitted.
module idct_prod_gen
  import dct_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEF,
  parameter int PROD_W = PROD_W_DEF,
  parameter int SHIFT  = SHIFT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [COEF_W-1:0] coef_in,
  input  logic                     coef_valid,
  output logic                     coef_ready,
  output logic signed [PROD_W-1:0] n0,
  output logic signed [PROD_W-1:0] n1,
  output logic signed [PROD_W-1:0] n2,
  output logic signed [PROD_W-1:0] n3,
  output logic signed [PROD_W-1:0] n4,
  output logic signed [PROD_W-1:0] n5,
  output logic signed [PROD_W-1:0] n6,
  output logic signed [PROD_W-1:0] n7,
  output logic                     prod_valid,
  output logic [2:0]               prod_row
);

  // Full multiply width: the product of a COEF_W and a T_W signed value.
  localparam int FULL_W = COEF_W + T_W;

  logic signed [COEF_W-1:0] mem [2][8];
  logic                     wr_bank;
  logic [2:0]               wr_cnt;
  logic [1:0]               full;
  logic [1:0]               full_set;
  logic [1:0]               full_clr;
  logic                     accept;

  emit_state_t              state_reg;
  emit_state_t              state_next;
  logic                     rd_bank;
  logic                     rd_bank_next;
  logic [2:0]               row_cnt;
  logic [2:0]               row_next;
  logic                     release_bank;

  logic signed [PROD_W-1:0] lane_next [8];
  logic signed [PROD_W-1:0] lane_reg  [8];

  // The write bank can only be full when both banks are full.
  assign coef_ready = ~full[wr_bank];
  assign accept     = coef_valid & coef_ready;

  // A bank becomes full on its 8th coefficient and is released after row 7.
  // Set and clear never target the same bank, since a full bank takes no writes.
  assign full_set = (accept && wr_cnt == 3'd7) ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign full_clr = release_bank ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

  // Coefficient storage; contents are only meaningful while the bank is full.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_bank][wr_cnt] <= coef_in;
    end
  end

  // Write pointer: counter wraps 7->0 and flips to the other bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      wr_cnt  <= 3'd0;
    end else if (accept) begin
      wr_cnt <= wr_cnt + 3'd1;
      if (wr_cnt == 3'd7) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  // Bank-full flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 2'b00;
    end else begin
      full <= (full & ~full_clr) | full_set;
    end
  end

  // Output FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      rd_bank   <= 1'b0;
      row_cnt   <= 3'd0;
    end else begin
      state_reg <= state_next;
      rd_bank   <= rd_bank_next;
      row_cnt   <= row_next;
    end
  end

  // Output FSM next state: start on any full bank, chain straight into the
  // other bank after row 7 when it is already full.
  always_comb begin
    state_next   = state_reg;
    rd_bank_next = rd_bank;
    row_next     = row_cnt;
    release_bank = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|full) begin
          state_next   = EMIT;
          rd_bank_next = ~full[0];
          row_next     = 3'd0;
        end
      end
      EMIT: begin
        if (row_cnt == 3'd7) begin
          release_bank = 1'b1;
          row_next     = 3'd0;
          if (full[~rd_bank]) begin
            rd_bank_next = ~rd_bank;
          end else begin
            state_next = IDLE;
          end
        end else begin
          row_next = row_cnt + 3'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Product lanes: lane k multiplies X_k by T[row][k]. The range of the
  // operands keeps the shifted product inside PROD_W, so a plain truncation
  // of the upper bits is exact.
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    logic signed [T_W-1:0]    t;
    logic signed [FULL_W-1:0] coef_ext;
    logic signed [FULL_W-1:0] t_ext;
    logic signed [FULL_W-1:0] prod;
    logic signed [FULL_W-1:0] shifted;
    logic [FULL_W-PROD_W-1:0] shifted_unused;

    idct_cos_rom u_rom (
      .row  (row_cnt),
      .term (3'(gi)),
      .t    (t)
    );

    assign coef_ext          = {{T_W{mem[rd_bank][gi][COEF_W-1]}}, mem[rd_bank][gi]};
    assign t_ext             = {{COEF_W{t[T_W-1]}}, t};
    assign prod              = coef_ext * t_ext;
    assign shifted           = prod >>> SHIFT;
    assign lane_next[gi]     = shifted[PROD_W-1:0];
    assign shifted_unused    = shifted[FULL_W-1:PROD_W];
  end

  // Output register: capture a row while emitting, otherwise hold the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_valid <= 1'b0;
      prod_row   <= 3'd0;
      for (int k = 0; k < 8; k++) begin
        lane_reg[k] <= '0;
      end
    end else if (state_reg == EMIT) begin
      prod_valid <= 1'b1;
      prod_row   <= row_cnt;
      lane_reg   <= lane_next;
    end else begin
      prod_valid <= 1'b0;
    end
  end

  assign n0 = lane_reg[0];
  assign n1 = lane_reg[1];
  assign n2 = lane_reg[2];
  assign n3 = lane_reg[3];
  assign n4 = lane_reg[4];
  assign n5 = lane_reg[5];
  assign n6 = lane_reg[6];
  assign n7 = lane_reg[7];

endmodule

// File: tb/tb_idct_prod_gen.sv
// Bench for idct_prod_gen. A collector records every emitted row with its
// cycle stamp; a reference model built from real cosine arithmetic predicts
// each row from the coefficients the DUT actually accepted.
module tb_idct_prod_gen;

  localparam int CW = 12;
  localparam int PW = 14;
  localparam int SH = 5;
  localparam real PI = 3.14159265358979;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic signed [CW-1:0] coef_in = '0;
  logic                 coef_valid = 1'b0;
  logic                 coef_ready;
  logic signed [PW-1:0] n0, n1, n2, n3, n4, n5, n6, n7;
  logic                 prod_valid;
  logic [2:0]           prod_row;

  idct_prod_gen #(.COEF_W(CW), .PROD_W(PW), .SHIFT(SH)) dut (
    .clk(clk), .rst_n(rst_n), .coef_in(coef_in), .coef_valid(coef_valid),
    .coef_ready(coef_ready), .n0(n0), .n1(n1), .n2(n2), .n3(n3), .n4(n4),
    .n5(n5), .n6(n6), .n7(n7), .prod_valid(prod_valid), .prod_row(prod_row)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [2:0] row; logic [7:0][PW-1:0] n; int cyc; } obs_t;
  typedef struct packed { logic [2:0] row; logic [7:0][31:0] n; } exp_t;

  obs_t                 obs_q[$];
  exp_t                 exp_q[$];
  logic signed [CW-1:0] src_q[$];
  int                   t_ref [8][8];
  int                   frame_buf [8];
  int                   acc_cnt = 0;
  int                   n_cmp = 0;
  int                   n_fail = 0;
  int                   last_acc_cyc = 0;
  int                   low_run_max = 0;
  int                   low_total = 0;

  // Record every valid row, sampled away from the rising edge.
  always @(negedge clk) begin : collect
    obs_t o;
    if (rst_n && prod_valid) begin
      o.row = prod_row;
      o.n   = {n7, n6, n5, n4, n3, n2, n1, n0};
      o.cyc = cyc;
      obs_q.push_back(o);
    end
  end

  function automatic int round_real(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  task automatic build_table();
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8; k++) begin
        real ck;
        ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        t_ref[i][k] = round_real(128.0 * ck * $cos(real'((2 * i + 1) * k) * PI / 16.0));
      end
    end
  endtask

  // Reference: every 8 accepted coefficients yield rows 0..7 of (X_k*T[i][k]) >>> SH.
  task automatic model_accept(input int x);
    frame_buf[acc_cnt] = x;
    acc_cnt++;
    if (acc_cnt == 8) begin
      acc_cnt = 0;
      for (int i = 0; i < 8; i++) begin
        exp_t e;
        e.row = 3'(i);
        for (int k = 0; k < 8; k++) e.n[k] = 32'((frame_buf[k] * t_ref[i][k]) >>> SH);
        exp_q.push_back(e);
      end
    end
  endtask

  // Offer `count` coefficients from src_q; called and returns at posedge+1.
  task automatic drive(input int count, input int gap_pct, output int accepted);
    int guard = 0;
    int run = 0;
    bit acc;
    accepted = 0;
    while (accepted < count && guard < count * 20 + 200) begin
      guard++;
      coef_valid = ($urandom_range(0, 99) >= gap_pct);
      coef_in    = src_q[0];
      acc        = coef_valid && coef_ready;
      if (coef_valid && !coef_ready) begin
        run++;
        low_total++;
        if (run > low_run_max) low_run_max = run;
      end else begin
        run = 0;
      end
      @(posedge clk); #1;
      if (acc) begin
        model_accept(int'(src_q.pop_front()));
        last_acc_cyc = cyc;
        accepted++;
      end
    end
    coef_valid = 1'b0;
  endtask

  task automatic wait_rows(input int want, input int budget, output bit ok);
    int waited = 0;
    while (obs_q.size() < want && waited < budget) begin
      @(posedge clk); #1;
      waited++;
    end
    ok = (obs_q.size() >= want);
  endtask

  task automatic clear_and_release();
    coef_valid = 1'b0;
    obs_q.delete();
    exp_q.delete();
    src_q.delete();
    acc_cnt = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_cmp++;
    if (prod_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", prod_valid); end
    n_cmp++;
    if (prod_row !== 3'd0) begin n_fail++; $display("FAIL reset_row got=%0d want=0", prod_row); end
    n_cmp++;
    if ({n7, n6, n5, n4, n3, n2, n1, n0} !== '0) begin n_fail++; $display("FAIL reset_lanes got=%h want=0", {n7, n6, n5, n4, n3, n2, n1, n0}); end
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (coef_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", coef_ready); end
    $display("[%0t] reset checked", $time);
  endtask

  task automatic test_basic();
    int acc;
    bit ok;
    int prev;
    int x0 [3] = '{1024, -1024, 0};
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 8; k++) src_q.push_back(k == 0 ? CW'(x0[f]) : (f == 2 && k == 1) ? CW'(64) : CW'(0));
      drive(8, 0, acc);
      n_cmp++;
      if (acc != 8) begin n_fail++; $display("FAIL basic_accept f=%0d got=%0d want=8", f, acc); end
      wait_rows(8, 40, ok);
      n_cmp++;
      if (!ok) begin n_fail++; $display("FAIL basic_timeout f=%0d got=%0d rows want=8", f, obs_q.size()); return; end
      prev = 0;
      for (int r = 0; r < 8; r++) begin
        obs_t o;
        int want0;
        int want1;
        o = obs_q.pop_front();
        void'(exp_q.pop_front());
        want0 = (f == 0) ? 2912 : (f == 1) ? -2912 : 0;
        want1 = (f == 2 && r == 0) ? 252 : int'($signed(o.n[1]));
        n_cmp++;
        if (o.row !== 3'(r)) begin n_fail++; $display("FAIL basic_row f=%0d got=%0d want=%0d", f, o.row, r); end
        n_cmp++;
        if (int'($signed(o.n[0])) != want0) begin n_fail++; $display("FAIL basic_n0 f=%0d r=%0d got=%0d want=%0d", f, r, $signed(o.n[0]), want0); end
        n_cmp++;
        if (int'($signed(o.n[1])) != want1) begin n_fail++; $display("FAIL basic_n1 f=%0d r=%0d got=%0d want=%0d", f, r, $signed(o.n[1]), want1); end
        if (f < 2) begin
          n_cmp++;
          if (o.n[7:1] !== '0) begin n_fail++; $display("FAIL basic_zero f=%0d r=%0d got=%h want=0", f, r, o.n[7:1]); end
        end
        if (r > 0) begin
          n_cmp++;
          if (o.cyc != prev + 1) begin n_fail++; $display("FAIL basic_consec f=%0d r=%0d got=%0d want=%0d", f, r, o.cyc, prev + 1); end
        end
        prev = o.cyc;
      end
      repeat (3) @(posedge clk); #1;
      n_cmp++;
      if (prod_valid !== 1'b0 || prod_row !== 3'd7 || int'(n0) != x0[f] * 91 / 32) begin
        n_fail++;
        $display("FAIL basic_hold f=%0d got=valid%b row%0d n0=%0d want=valid0 row7 n0=%0d", f, prod_valid, prod_row, n0, x0[f] * 91 / 32);
      end
      $display("[%0t] basic frame X0=%0d rows checked", $time, x0[f]);
    end
  endtask

  task automatic test_latency();
    int acc;
    bit ok;
    int t;
    for (int k = 0; k < 8; k++) src_q.push_back(CW'($urandom));
    drive(8, 0, acc);
    t = last_acc_cyc;
    wait_rows(8, 40, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL lat_timeout got=%0d rows want=8", obs_q.size()); return; end
    repeat (3) @(posedge clk); #1;
    n_cmp++;
    if (obs_q.size() != 8) begin n_fail++; $display("FAIL lat_count got=%0d want=8", obs_q.size()); end
    for (int r = 0; r < 8; r++) begin
      obs_t o;
      exp_t e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o.cyc != t + 2 + r) begin n_fail++; $display("FAIL lat_cycle r=%0d got=%0d want=%0d", r, o.cyc, t + 2 + r); end
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if (int'($signed(o.n[k])) != int'($signed(e.n[k]))) begin n_fail++; $display("FAIL lat_lane r=%0d k=%0d got=%0d want=%0d", r, k, $signed(o.n[k]), $signed(e.n[k])); end
      end
    end
    obs_q.delete();
    $display("[%0t] latency frame accepted at edge %0d checked", $time, t);
  endtask

  task automatic test_back_to_back();
    int acc;
    bit ok;
    int c0;
    low_run_max = 0;
    low_total = 0;
    for (int k = 0; k < 24; k++) src_q.push_back(CW'($urandom));
    drive(24, 0, acc);
    n_cmp++;
    if (acc != 24) begin n_fail++; $display("FAIL b2b_accept got=%0d want=24", acc); end
    n_cmp++;
    if (low_run_max > 1 || low_total > 3) begin n_fail++; $display("FAIL b2b_ready_low got=run%0d total%0d want=run<=1 total<=3", low_run_max, low_total); end
    wait_rows(24, 80, ok);
    repeat (3) @(posedge clk); #1;
    n_cmp++;
    if (obs_q.size() != 24 || exp_q.size() != 24) begin n_fail++; $display("FAIL b2b_count got=%0d exp=%0d want=24", obs_q.size(), exp_q.size()); return; end
    c0 = obs_q[0].cyc;
    for (int r = 0; r < 24; r++) begin
      obs_t o;
      exp_t e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o.row !== e.row) begin n_fail++; $display("FAIL b2b_row idx=%0d got=%0d want=%0d", r, o.row, e.row); end
      if (r < 16) begin
        n_cmp++;
        if (o.cyc != c0 + r) begin n_fail++; $display("FAIL b2b_gap idx=%0d got=%0d want=%0d", r, o.cyc, c0 + r); end
      end
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if (int'($signed(o.n[k])) != int'($signed(e.n[k]))) begin n_fail++; $display("FAIL b2b_lane idx=%0d k=%0d got=%0d want=%0d", r, k, $signed(o.n[k]), $signed(e.n[k])); end
      end
    end
    $display("[%0t] back-to-back 3 frames checked, ready-low cycles=%0d", $time, low_total);
  endtask

  task automatic test_mid_reset();
    int acc;
    bit ok;
    for (int k = 0; k < 5; k++) src_q.push_back(CW'($urandom));
    drive(5, 0, acc);
    n_cmp++;
    if (acc != 5) begin n_fail++; $display("FAIL midrst_partial got=%0d want=5", acc); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (prod_valid !== 1'b0 || prod_row !== 3'd0 || {n7, n6, n5, n4, n3, n2, n1, n0} !== '0) begin
      n_fail++; $display("FAIL midrst_partial_out got=valid%b row%0d lanes=%h want=0", prod_valid, prod_row, {n7, n6, n5, n4, n3, n2, n1, n0});
    end
    clear_and_release();
    n_cmp++;
    if (coef_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got=%b want=1", coef_ready); end
    for (int k = 0; k < 8; k++) src_q.push_back(CW'($urandom));
    drive(8, 0, acc);
    wait_rows(3, 40, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL midrst_emit_timeout got=%0d want=3", obs_q.size()); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (prod_valid !== 1'b0 || prod_row !== 3'd0 || {n7, n6, n5, n4, n3, n2, n1, n0} !== '0) begin
      n_fail++; $display("FAIL midrst_emit_out got=valid%b row%0d lanes=%h want=0", prod_valid, prod_row, {n7, n6, n5, n4, n3, n2, n1, n0});
    end
    clear_and_release();
    for (int k = 0; k < 8; k++) src_q.push_back(CW'($urandom));
    drive(8, 0, acc);
    wait_rows(8, 40, ok);
    repeat (12) @(posedge clk); #1;
    n_cmp++;
    if (obs_q.size() != 8) begin n_fail++; $display("FAIL midrst_count got=%0d want=8", obs_q.size()); return; end
    for (int r = 0; r < 8; r++) begin
      obs_t o;
      exp_t e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o.row !== e.row) begin n_fail++; $display("FAIL midrst_row idx=%0d got=%0d want=%0d", r, o.row, e.row); end
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if (int'($signed(o.n[k])) != int'($signed(e.n[k]))) begin n_fail++; $display("FAIL midrst_lane r=%0d k=%0d got=%0d want=%0d", r, k, $signed(o.n[k]), $signed(e.n[k])); end
      end
    end
    $display("[%0t] mid-operation resets and recovery frame checked", $time);
  endtask

  task automatic test_random();
    int acc;
    bit ok;
    int nfr = 1000;
    for (int k = 0; k < nfr * 8; k++) begin
      case ($urandom_range(0, 15))
        0:       src_q.push_back(-CW'(2048));
        1:       src_q.push_back(CW'(2047));
        default: src_q.push_back(CW'($urandom));
      endcase
    end
    drive(nfr * 8, 25, acc);
    n_cmp++;
    if (acc != nfr * 8) begin n_fail++; $display("FAIL rand_accept got=%0d want=%0d", acc, nfr * 8); end
    wait_rows(nfr * 8, 200, ok);
    repeat (3) @(posedge clk); #1;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size()); return; end
    for (int r = 0; r < nfr * 8 && obs_q.size() > 0; r++) begin
      obs_t o;
      exp_t e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o.row !== e.row) begin n_fail++; $display("FAIL rand_row idx=%0d got=%0d want=%0d", r, o.row, e.row); end
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if (int'($signed(o.n[k])) != int'($signed(e.n[k]))) begin n_fail++; $display("FAIL rand_lane idx=%0d k=%0d got=%0d want=%0d", r, k, $signed(o.n[k]), $signed(e.n[k])); end
      end
    end
    $display("[%0t] random %0d frames checked", $time, nfr);
  endtask

  initial begin
    build_table();
    test_reset();
    test_basic();
    test_latency();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=time %0t want=finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/idct_prod_gen.md
IDCT_PROD_GEN -- requirements
Module: idct_prod_gen

Interface
REQ-001 SHALL have parameter COEF_W, default 12: signed coefficient width, matching the adder-tree dct output.
REQ-002 SHALL have parameter PROD_W, default 14: signed product width, matching the adder-tree n0..n7 inputs.
REQ-003 SHALL have parameter SHIFT, default 5: arithmetic right shift applied to each raw product.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port coef_in, input, COEF_W: two's-complement DCT coefficient X_k, presented in order k=0..7.
REQ-007 SHALL have port coef_valid, input, 1: coef_in is valid this cycle.
REQ-008 SHALL have port coef_ready, output, 1: block can accept coef_in this cycle.
REQ-009 SHALL have ports n0..n7, output, PROD_W each: signed products X_k*T[i][k] >>> SHIFT for output row i, with n_k carrying term k.
REQ-010 SHALL have port prod_valid, output, 1: n0..n7 and prod_row are valid this cycle.
REQ-011 SHALL have port prod_row, output, 3: sample index i of the current product row.

Function
REQ-012 SHALL accept a coefficient only on a cycle where coef_valid=1 and coef_ready=1; nothing else SHALL advance the input counter.
REQ-013 SHALL store accepted coefficients in two 8-entry banks used ping-pong; a 3-bit write counter SHALL wrap 7->0 and toggle the write bank.
REQ-014 SHALL mark a bank full on acceptance of its 8th coefficient, and free it after its row 7 is emitted.
REQ-015 SHALL drive coef_ready=0 exactly when the write bank is full, meaning both banks are full; at most one bubble per frame.
REQ-016 SHALL implement an output FSM with states IDLE and EMIT.
- IDLE->EMIT when any bank is full; row counter=0.
- EMIT: one row per cycle, i=0..7.
- After i=7: stay in EMIT on the other bank if it is full (no gap), else return to IDLE.
REQ-017 SHALL use T[i][k] = round(128*c_k*cos((2i+1)k*pi/16)), with c_0=1/sqrt2 and c_k=1 otherwise, as signed 9-bit constants (T[i][0]=91, T[0][1]=126).
REQ-018 SHALL form each product as a full 21-bit signed multiply, arithmetic-shift it right by SHIFT, and take bits [PROD_W-1:0]; range analysis (|2048*126|>>5 = 8064) SHALL guarantee no overflow, so no saturation.
REQ-019 SHALL register the product (one pipeline stage): if the 8th coefficient of a frame is accepted at edge t and the FSM is in IDLE, row 0 SHALL be valid after edge t+2 and row 7 after edge t+9.
REQ-020 SHALL hold n0..n7 and prod_row at their last values while prod_valid=0.
REQ-021 SHALL handle simultaneous acceptance into one bank and emission of row 7 from the other correctly, with no lost or duplicated coefficient.

Reset
REQ-022 SHALL, on rst_n=0, immediately clear:
- n0..n7 to 0, prod_valid to 0, prod_row to 0;
- the write counter and bank-full flags;
- the FSM, returning it to IDLE.
REQ-023 SHALL drive coef_ready=1 from the first edge after reset release.
REQ-024 SHALL discard partial frames and in-progress emission on a mid-operation reset; no rows from them SHALL appear afterwards.

Structure
REQ-025 SHALL place COEF_W/PROD_W/SHIFT defaults and the 8x8 T table in shared package dct_pkg.
REQ-026 SHALL use one sub-module, idct_cos_rom: combinational lookup (i,k)->T[i][k], instantiated once per product lane.

Verification
REQ-027 SHALL verify: frame X0=1024, X1..X7=0 -> rows 0..7 each give n0=2912, n1..n7=0, with prod_row 0..7 on consecutive cycles.
REQ-028 SHALL verify: X0=-1024 -> n0=-2912 on all rows; X1=64, others 0 -> row 0 n1=252.
REQ-029 SHALL verify: 8th coefficient accepted at edge t -> prod_valid rises after edge t+2 and stays high 8 cycles.
REQ-030 SHALL verify: 24 coefficients streamed with coef_valid=1 continuously -> 24 rows emitted back-to-back, coef_ready low for at most one cycle per frame, no data loss.
REQ-031 SHALL verify: rst_n asserted after 5 coefficients and again mid-EMIT -> outputs 0 at once; the next full frame is emitted correctly.
REQ-032 SHALL verify: random coefficients over 1000 frames -> every lane matches the reference model (X_k*T[i][k]) >>> 5.
